// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, frame bit positions and FSM encoding for dac_frame_sched
package dds_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int WORD_W_DEF = DATA_W_DEF + 4;
  localparam int FRM_CH     = 15;
  localparam int FRM_BUF    = 14;
  localparam int FRM_GA     = 13;
  localparam int FRM_SHDN   = 12;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_LDAC} state_t;
endpackage

// File: rtl/dac_frame_sched_if.sv
// dac_frame_sched_if: frame handshake between scheduler (master) and SPI serializer (slave)
interface dac_frame_sched_if
  import dds_pkg::*;
#(parameter int WORD_W = WORD_W_DEF) ();
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              tx_done;
  modport master (output word_out, word_valid, input word_ready, tx_done);
  modport slave  (input word_out, word_valid, output word_ready, tx_done);
endinterface

// File: rtl/dac_sched_chan_hold.sv
// dac_sched_chan_hold: per-voice sample latch with pending flag and sticky overrun
module dac_sched_chan_hold
  import dds_pkg::*;
#(parameter int DATA_W = DATA_W_DEF) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_grant,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_hold,
  output logic              o_pend,
  output logic              o_ovr
);
  logic [DATA_W-1:0] r_hold;
  logic              r_pend, r_ovr;
  // a grant reads the old hold value, so a same-cycle capture is never an overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hold <= '0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (i_valid) r_hold <= i_data;
      r_pend <= i_valid | (r_pend & ~i_grant);
      r_ovr  <= ~i_clr & (r_ovr | (i_valid & r_pend & ~i_grant));
    end
  assign o_hold = r_hold;
  assign o_pend = r_pend;
  assign o_ovr  = r_ovr;
endmodule

// File: rtl/dac_frame_sched.sv
// dac_frame_sched: round-robin scheduler building dual-DAC frames from two voices.
// Define DAC_SCHED_LDAC_EN to pulse ldac_n after each complete ch0+ch1 pair.
module dac_frame_sched
  import dds_pkg::*;
#(
  parameter int   DATA_W = DATA_W_DEF,
  parameter int   WORD_W = DATA_W + 4,
  parameter logic BUF    = 1'b0,
  parameter logic GA_N   = 1'b1
`ifdef DAC_SCHED_LDAC_EN
  , parameter int LDAC_PULSE = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  input  logic              shdn_n,
  input  logic              clr_ovr,
  output logic              ldac_n,
  output logic              busy,
  output logic [1:0]        ovr,
  dac_frame_sched_if.master ser
);
  state_t            r_state, w_nxt;
  logic              r_last, w_ch, w_grant;
  logic [WORD_W-1:0] r_word, w_frame;
  logic [1:0]        w_pend, w_gnt;
  logic [DATA_W-1:0] w_hold0, w_hold1;
  dac_sched_chan_hold #(.DATA_W(DATA_W)) u_ch0 (
    .clk, .rst_n, .i_data(ch0_data), .i_valid(ch0_valid), .i_grant(w_gnt[0]),
    .i_clr(clr_ovr), .o_hold(w_hold0), .o_pend(w_pend[0]), .o_ovr(ovr[0]));
  dac_sched_chan_hold #(.DATA_W(DATA_W)) u_ch1 (
    .clk, .rst_n, .i_data(ch1_data), .i_valid(ch1_valid), .i_grant(w_gnt[1]),
    .i_clr(clr_ovr), .o_hold(w_hold1), .o_pend(w_pend[1]), .o_ovr(ovr[1]));
  // with both pending, the channel not served last wins
  assign w_ch    = &w_pend ? ~r_last : w_pend[1];
  assign w_grant = r_state == S_IDLE && en && |w_pend;
  assign w_gnt   = {w_grant & w_ch, w_grant & ~w_ch};
  always_comb begin
    w_frame             = '0;
    w_frame[FRM_CH]     = w_ch;
    w_frame[FRM_BUF]    = BUF;
    w_frame[FRM_GA]     = GA_N;
    w_frame[FRM_SHDN]   = shdn_n;
    w_frame[DATA_W-1:0] = w_ch ? w_hold1 : w_hold0;
  end
`ifdef DAC_SCHED_LDAC_EN
  logic [1:0] r_mask;
  logic [3:0] r_cnt;
  logic       w_pulse_end;
  assign w_pulse_end = r_cnt == 4'(LDAC_PULSE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mask <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_state == S_ISSUE && ser.word_ready) r_mask[r_word[FRM_CH]] <= 1'b1;
      if (r_state == S_LDAC && w_pulse_end) r_mask <= '0;
      r_cnt <= r_state == S_LDAC ? r_cnt + 4'd1 : 4'd0;
    end
  assign ldac_n = r_state != S_LDAC;
`else
  assign ldac_n = 1'b0;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:      w_nxt = w_grant ? S_ISSUE : S_IDLE;
      S_ISSUE:     w_nxt = ser.word_ready ? S_WAIT_DONE : S_ISSUE;
`ifdef DAC_SCHED_LDAC_EN
      S_WAIT_DONE: w_nxt = ser.tx_done ? (&r_mask ? S_LDAC : S_IDLE) : S_WAIT_DONE;
      S_LDAC:      w_nxt = w_pulse_end ? S_IDLE : S_LDAC;
`else
      S_WAIT_DONE: w_nxt = ser.tx_done ? S_IDLE : S_WAIT_DONE;
`endif
      default:     w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      if (w_grant) begin
        r_word <= w_frame;
        r_last <= w_ch;
      end
    end
  assign ser.word_out   = r_word;
  assign ser.word_valid = r_state == S_ISSUE;
  assign busy           = r_state != S_IDLE;
endmodule

// File: tb/tb_dac_frame_sched.sv
// tb_dac_frame_sched: directed scenarios plus randomized run against a behavioural scheduler model
module tb_dac_frame_sched;
  import dds_pkg::*;
`ifdef DAC_SCHED_LDAC_EN
  localparam logic LDAC_IDLE = 1'b1;
  localparam int   LDAC_LOW  = 2;
`else
  localparam logic LDAC_IDLE = 1'b0;
  localparam int   LDAC_LOW  = 7;
`endif
  logic        clk, rst_n, en, ch0_valid, ch1_valid, shdn_n, clr_ovr, ldac_n, busy;
  logic [11:0] ch0_data, ch1_data;
  logic [1:0]  ovr;
  int          n_chk = 0, n_err = 0;
  dac_frame_sched_if ser();
  dac_frame_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch0_data(ch0_data), .ch0_valid(ch0_valid),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .shdn_n(shdn_n), .clr_ovr(clr_ovr),
    .ldac_n(ldac_n), .busy(busy), .ovr(ovr), .ser(ser));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic strobe(input logic v0, input logic [11:0] d0, input logic v1, input logic [11:0] d1);
    ch0_valid = v0; ch0_data = d0; ch1_valid = v1; ch1_data = d1;
    step();
    ch0_valid = 1'b0; ch1_valid = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !ser.word_valid; i++) step();
    chk(tag, ser.word_valid, 1'b1);
  endtask
  task automatic serve(input string tag, input logic [15:0] exp);
    wait_valid({tag, "_v"});
    chk(tag, ser.word_out, exp);
    ser.word_ready = 1'b1;
    step();
    ser.word_ready = 1'b0;
    chk({tag, "_acc"}, ser.word_valid, 1'b0);
    ser.tx_done = 1'b1;
    step();
    ser.tx_done = 1'b0;
  endtask
  logic        m_pend[2], m_ovr[2], m_last, gch, prev_b, prev_v, g;
  logic [11:0] m_hold[2];
  logic [15:0] exp_w;
  int          cd, lows;
  initial begin
    rst_n = 1'b1; en = 1'b1; shdn_n = 1'b1; clr_ovr = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_data = '0; ch1_data = '0;
    ser.word_ready = 1'b0; ser.tx_done = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_word", ser.word_out, 16'h0);
    chk("rst_valid", ser.word_valid, 1'b0);
    chk("rst_ldac", ldac_n, LDAC_IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", ovr, 2'b00);
    step();
    rst_n = 1'b1;
    strobe(1'b1, 12'hABC, 1'b0, 12'h0);
    serve("single", 16'h3ABC);
    chk("single_idle", busy, 1'b0);
    do_reset();
    strobe(1'b1, 12'h111, 1'b1, 12'h222);
    serve("pair0", 16'h3111);
    serve("pair1", 16'hB222);
    lows = 0;
    for (int i = 0; i < 7; i++) begin
      lows += int'(!ldac_n);
      if (i < 6) step();
    end
    chk("ldac_width", lows, LDAC_LOW);
    strobe(1'b1, 12'h5A5, 1'b0, 12'h0);
    wait_valid("stall_v");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", ser.word_valid, 1'b1);
      chk("stall_word", ser.word_out, 16'h35A5);
    end
    ser.word_ready = 1'b1;
    step();
    ser.word_ready = 1'b0;
    chk("stall_acc", ser.word_valid, 1'b0);
    ser.tx_done = 1'b1;
    step();
    ser.tx_done = 1'b0;
    strobe(1'b1, 12'h777, 1'b0, 12'h0);
    wait_valid("ovr_v");
    strobe(1'b0, 12'h0, 1'b1, 12'h005);
    chk("ovr_first", ovr, 2'b00);
    strobe(1'b0, 12'h0, 1'b1, 12'h006);
    chk("ovr_set", ovr, 2'b10);
    serve("ovr_ch0", 16'h3777);
    serve("ovr_ch1", 16'hB006);
    chk("ovr_sticky", ovr, 2'b10);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", ovr, 2'b00);
    for (int i = 0; i < 6 && busy; i++) step();
    strobe(1'b1, 12'h123, 1'b0, 12'h0);
    wait_valid("arst_v");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ser.word_valid, 1'b0);
    chk("arst_ldac", ldac_n, LDAC_IDLE);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("arst_quiet", {busy, ser.word_valid}, 2'b00);
    en = 1'b0;
    strobe(1'b1, 12'h0A1, 1'b1, 12'h0B2);
    for (int i = 0; i < 8; i++) step();
    chk("en_block", {busy, ser.word_valid}, 2'b00);
    en = 1'b1;
    serve("en_ch0", 16'h30A1);
    serve("en_ch1", 16'hB0B2);
    do_reset();
    m_pend = '{1'b0, 1'b0}; m_ovr = '{1'b0, 1'b0}; m_hold = '{12'h0, 12'h0};
    m_last = 1'b1; prev_b = 1'b0; prev_v = 1'b0; cd = -1; exp_w = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ch0_valid = $urandom_range(0, 3) == 0; ch0_data = 12'($urandom);
      ch1_valid = $urandom_range(0, 3) == 0; ch1_data = 12'($urandom);
      clr_ovr = $urandom_range(0, 15) == 0;
      en = $urandom_range(0, 7) != 0;
      shdn_n = 1'($urandom);
      ser.word_ready = 1'($urandom);
      ser.tx_done = cd == 0;
      cd = cd > 0 ? cd - 1 : -1;
      step();
      g = !prev_b && en && (m_pend[0] || m_pend[1]);
      chk("rnd_grant", ser.word_valid && !prev_b, g);
      if (g) begin
        gch = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
        exp_w = {gch, 1'b0, 1'b1, shdn_n, m_hold[gch]};
        m_last = gch;
        m_pend[gch] = 1'b0;
      end
      if (ser.word_valid) chk("rnd_frame", ser.word_out, exp_w);
      if (prev_v && ser.word_ready) begin
        chk("rnd_accept", ser.word_valid, 1'b0);
        cd = $urandom_range(0, 3);
      end
      if (ch0_valid) begin
        if (m_pend[0]) m_ovr[0] = 1'b1;
        m_hold[0] = ch0_data; m_pend[0] = 1'b1;
      end
      if (ch1_valid) begin
        if (m_pend[1]) m_ovr[1] = 1'b1;
        m_hold[1] = ch1_data; m_pend[1] = 1'b1;
      end
      if (clr_ovr) m_ovr = '{1'b0, 1'b0};
      chk("rnd_ovr", ovr, {m_ovr[1], m_ovr[0]});
      prev_v = ser.word_valid;
      prev_b = busy;
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
